// File: rtl/timing_gen.sv
// timing_gen -- beat/phase timing generator for the hardwired controller.
//
// Generates the one-hot phase strobes t1/t2/t3 (three clocks per beat) and the
// one-hot beat signals w1/w2/w3. At the end of each beat it samples the
// controller's short/long/stop requests to pick the next beat or to halt. A
// halted machine is restarted by a rising edge on the front-panel start
// button qd.
//
// Parameters:
//   SYNC_STAGES  depth of the qd synchronizer (minimum 2)
//   CNT_W        width of the completed-sequence counter
//
// Ports:
//   clk      system clock, rising edge active
//   clr      asynchronous active-high reset
//   qd       start push-button (asynchronous level)
//   short    end the sequence after W1
//   long     extend the sequence to W3
//   stop     halt at the end of the current beat
//   t1..t3   phase strobes (t3 is the controller's state-update phase)
//   w1..w3   beat signals
//   running  1 while phases advance, 0 while halted
//   seq_cnt  number of completed beat sequences (wraps)

module timing_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             qd,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] seq_cnt
);

    // Phase encoding is {running, t3, t2, t1}, so every phase-related output
    // is a flop bit taken directly from the state register.
    typedef enum logic [3:0] {
        PH_HALT = 4'b0000,
        PH_T1   = 4'b1001,
        PH_T2   = 4'b1010,
        PH_T3   = 4'b1100
    } phase_e;

    // Beat encoding is {w3, w2, w1}.
    typedef enum logic [2:0] {
        BT_W1 = 3'b001,
        BT_W2 = 3'b010,
        BT_W3 = 3'b100
    } beat_e;

    phase_e phase_q, phase_d;
    beat_e  beat_q,  beat_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   start_rise;
    logic                   seq_last;
    logic                   cnt_inc;
    logic [CNT_W-1:0]       cnt_q;

    // ------------------------------------------------------------------
    // Start button: synchronizer chain followed by a one-flop edge detect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], qd};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign start_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            phase_q <= PH_HALT;
            beat_q  <= BT_W1;
        end else begin
            phase_q <= phase_d;
            beat_q  <= beat_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        phase_d  = phase_q;
        beat_d   = beat_q;
        cnt_inc  = 1'b0;
        seq_last = 1'b0;

        // The current beat ends its sequence if no further beat follows.
        case (beat_q)
            BT_W1:   seq_last = short;
            BT_W2:   seq_last = ~long;
            BT_W3:   seq_last = 1'b1;
            default: seq_last = 1'b0;
        endcase

        case (phase_q)
            PH_HALT: begin
                beat_d = BT_W1;
                if (start_rise) begin
                    phase_d = PH_T1;
                end
            end
            PH_T1: phase_d = PH_T2;
            PH_T2: phase_d = PH_T3;
            PH_T3: begin
                // End of beat. A sequence that finishes here is counted
                // whether or not the machine also halts.
                cnt_inc = seq_last;
                if (stop) begin
                    // Any start edge seen this cycle is dropped: the halt
                    // state only reacts to start_rise on later cycles.
                    phase_d = PH_HALT;
                    beat_d  = BT_W1;
                end else begin
                    phase_d = PH_T1;
                    case (beat_q)
                        BT_W1:   beat_d = short ? BT_W1 : BT_W2;
                        BT_W2:   beat_d = long  ? BT_W3 : BT_W1;
                        default: beat_d = BT_W1;
                    endcase
                end
            end
            default: begin
                phase_d = PH_HALT;
                beat_d  = BT_W1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Completed-sequence counter (wraps silently).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from flop bits.
    // ------------------------------------------------------------------
    assign running = phase_q[3];
    assign t3      = phase_q[2];
    assign t2      = phase_q[1];
    assign t1      = phase_q[0];
    assign w3      = beat_q[2];
    assign w2      = beat_q[1];
    assign w1      = beat_q[0];
    assign seq_cnt = cnt_q;

endmodule

// File: tb/tb_timing_gen.sv
// Testbench for timing_gen: directed stimulus pushes hand-computed expected
// states into a scoreboard; a monitor compares them on the falling edge.
// A second instance built with CNT_W=4 shares the stimulus to show wrap.

module tb_timing_gen;

    logic        clk = 1'b0;
    logic        clr, qd, short, long, stop;
    logic        t1, t2, t3, w1, w2, w3, running;
    logic [15:0] seq_cnt;
    logic        b_t1, b_t2, b_t3, b_w1, b_w2, b_w3, b_running;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    timing_gen #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
        .t1(t1), .t2(t2), .t3(t3), .w1(w1), .w2(w2), .w3(w3),
        .running(running), .seq_cnt(seq_cnt)
    );

    timing_gen #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
        .t1(b_t1), .t2(b_t2), .t3(b_t3), .w1(b_w1), .w2(b_w2), .w3(b_w3),
        .running(b_running), .seq_cnt(b_cnt)
    );

    typedef struct {
        int         tag;   // edge count after which the state must hold
        logic       r;
        logic [2:0] t;     // {t3,t2,t1}
        logic [2:0] w;     // {w3,w2,w1}
        int         c;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   edges   = 0;
    int   passed  = 0;
    int   total   = 0;
    int   step_id = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string nm, input int got, input int exp_v);
        total++;
        if (got == exp_v) passed++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp_v);
    endtask

    task automatic check_state(input string pfx, input exp_t e);
        check($sformatf("%s%0d_running", pfx, e.id), int'(running), int'(e.r));
        check($sformatf("%s%0d_t", pfx, e.id), int'({t3, t2, t1}), int'(e.t));
        check($sformatf("%s%0d_w", pfx, e.id), int'({w3, w2, w1}), int'(e.w));
        check($sformatf("%s%0d_cnt", pfx, e.id), int'(seq_cnt), e.c % 65536);
        check($sformatf("%s%0d_cnt4", pfx, e.id), int'(b_cnt), e.c % 16);
        check($sformatf("%s%0d_tw4", pfx, e.id),
              int'({b_running, b_t3, b_t2, b_t1, b_w3, b_w2, b_w1}),
              int'({e.r, e.t, e.w}));
    endtask

    // Monitor: pops every expectation due at the current edge count.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= edges) begin
            e = sb.pop_front();
            check_state("step", e);
        end
    end

    task automatic step(input logic r, input logic [2:0] t, input logic [2:0] w, input int c);
        exp_t e;
        e.tag = edges + 1;
        e.r   = r;
        e.t   = t;
        e.w   = w;
        e.c   = c;
        e.id  = step_id;
        step_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic imm_check(input string nm);
        exp_t e;
        e.tag = 0; e.r = 1'b0; e.t = 3'b000; e.w = 3'b001; e.c = 0; e.id = 0;
        check_state(nm, e);
    endtask

    // Phase after step j when the run started at t1: t2, t3, t1, ...
    function automatic logic [2:0] ph(input int j);
        if (j % 3 == 0) return 3'b010;
        if (j % 3 == 1) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic [2:0] bt(input int b);
        logic [2:0] one;
        one = 3'b001;
        return one << b;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        imm_check("reset");
        clr = 1'b0;

        // Start: qd high for 10 clk; t1 appears after the 3rd sampling edge.
        short = 1'b1;
        qd    = 1'b1;
        step(1'b0, 3'b000, 3'b001, 0);
        step(1'b0, 3'b000, 3'b001, 0);
        step(1'b1, 3'b001, 3'b001, 0);

        // short: W1-only sequences, one count per 3 clk; 17 sequences.
        for (int j = 0; j < 51; j++) begin
            if (j == 7) qd = 1'b0;
            step(1'b1, ph(j), 3'b001, (j + 1) / 3);
        end

        // Neither short nor long: W1,W2 alternating, one count per 6 clk.
        short = 1'b0;
        for (int j = 0; j < 12; j++)
            step(1'b1, ph(j), bt(((j + 1) / 3) % 2), 17 + (j + 1) / 6);

        // long: W1,W2,W3, one count per 9 clk.
        long = 1'b1;
        for (int j = 0; j < 18; j++)
            step(1'b1, ph(j), bt(((j + 1) / 3) % 3), 19 + (j + 1) / 9);

        // stop during W2/t2; a qd edge detected in the stop cycle is dropped.
        long = 1'b0;
        step(1'b1, 3'b010, 3'b001, 21);
        step(1'b1, 3'b100, 3'b001, 21);
        step(1'b1, 3'b001, 3'b010, 21);
        qd = 1'b1;
        step(1'b1, 3'b010, 3'b010, 21);
        stop = 1'b1;
        step(1'b1, 3'b100, 3'b010, 21);
        step(1'b0, 3'b000, 3'b001, 22);
        stop = 1'b0;
        repeat (6) step(1'b0, 3'b000, 3'b001, 22);
        qd = 1'b0;
        repeat (3) step(1'b0, 3'b000, 3'b001, 22);

        // A fresh qd pulse resumes at W1/t1.
        qd = 1'b1;
        step(1'b0, 3'b000, 3'b001, 22);
        step(1'b0, 3'b000, 3'b001, 22);
        step(1'b1, 3'b001, 3'b001, 22);
        step(1'b1, 3'b010, 3'b001, 22);
        step(1'b1, 3'b100, 3'b001, 22);
        step(1'b1, 3'b001, 3'b010, 22);
        step(1'b1, 3'b010, 3'b010, 22);

        // Asynchronous reset in the middle of W2/t2.
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        imm_check("midreset");
        qd = 1'b0;
        @(posedge clk);
        #1;
        imm_check("heldreset");
        clr = 1'b0;
        repeat (4) step(1'b0, 3'b000, 3'b001, 0);

        @(negedge clk);
        #1;
        check("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Beat/phase timing generator for the hardwired controller.
- Produces the beat signals w1/w2/w3 and phase strobes t1/t2/t3.
- Consumes the controller's short/long/stop requests to sequence beats, halt the machine and resume it on the front-panel start button.
- Sits directly upstream of the controller. It also receives the controller's beat-sequencing outputs back.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the qd (start button) synchronizer; minimum 2.
- CNT_W, 16, width of the completed-sequence counter seq_cnt.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- qd  input  1  start push-button; asynchronous, level, active-high.
- short  input  1  controller request: end the sequence after W1.
- long  input  1  controller request: extend the sequence to W3.
- stop  input  1  controller request: halt at the end of the current beat.
- t1  output  1  phase 1 strobe.
- t2  output  1  phase 2 strobe.
- t3  output  1  phase 3 strobe; the controller's state-update phase.
- w1  output  1  beat 1 active.
- w2  output  1  beat 2 active.
- w3  output  1  beat 3 active.
- running  output  1  1 while phases advance; 0 while halted.
- seq_cnt  output  CNT_W  count of completed beat sequences.

Behaviour:
- Reset (clr=1, asynchronous):
  - t1=t2=t3=0; w1=1, w2=w3=0; running=0; seq_cnt=0.
  - Synchronizer and edge-detect flops cleared.
  - Takes effect mid-beat or mid-phase immediately; no partial beat completes.
- Halted state (running=0):
  - t1..t3 all 0.
  - w1 held 1, w2=w3=0, so the controller can drive its W1 panel signals.
- Start:
  - qd passes through SYNC_STAGES flops, then a one-flop rising-edge detect.
  - A detected rising edge while halted sets running=1 and t1=1 on the next edge.
  - With SYNC_STAGES=2, t1 rises after the 3rd clk edge that samples qd=1.
  - qd held high produces exactly one start.
  - Start edges while running are ignored.
- Phase sequencing while running:
  - One-hot t1 -> t2 -> t3 -> t1, one clk each, so 3 clk per beat.
  - Exactly one of t1..t3 is high.
- End of beat: the clk edge with running=1 and t3=1. short, long and stop are sampled only at this edge; priority is stop > short > long.
  - stop=1: next beat is W1, running=0, t*=0. If the beat was the last of a sequence (W1 with short, W2 without long, or W3), seq_cnt increments. A start edge detected in the same cycle is discarded.
  - Beat W1: short=1 -> W1 and seq_cnt+1; else -> W2. long is ignored in W1.
  - Beat W2: long=1 -> W3; else -> W1 and seq_cnt+1. short is ignored in W2.
  - Beat W3: -> W1 and seq_cnt+1. short and long are ignored.
- Beat encoding:
  - w1/w2/w3 are one-hot at all times after reset.
  - Beat changes only at the end-of-beat edge.
- Counter: seq_cnt wraps from 2^CNT_W-1 to 0 silently.
- Glitch-free outputs: all outputs are registered.

Test Plan:
- Reset: assert clr mid-W2/t2 with running=1 -> outputs immediately go to w1=1, t*=0, running=0, seq_cnt=0. Stay so until a qd pulse.
- Start: pulse qd high for 10 clk while halted -> t1 rises after the 3rd sampling edge. Pattern t1,t2,t3 repeats every 3 clk; only one start occurs.
- short=1, long=0, stop=0 -> w1 stays 1 for every beat. seq_cnt increments by 1 every 3 clk; after 12 clk it reads 4.
- short=0, long=0 -> beats W1,W2,W1,W2. seq_cnt reaches 2 after 12 clk. Then long=1 -> W1,W2,W3 repeating, seq_cnt +1 per 9 clk.
- stop=1 asserted during W2/t2 with long=0 -> at the W2/t3 edge: running=0, w1=1, t*=0, seq_cnt+1. A qd edge in that same cycle is ignored; a later qd pulse resumes at W1/t1.
- CNT_W=4 build: run 17 short sequences from reset -> seq_cnt reads 1, confirming the wrap.
